hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters gate issue on
// RAW hazards, in-flight capacity and per-register counter saturation.
module hazard_scoreboard #(
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_valid,
   input  logic [4:0] issue_rs1,
   input  logic [4:0] issue_rs2,
   input  logic       issue_use_rs1,
   input  logic       issue_use_rs2,
   input  logic [4:0] issue_rd,
   input  logic       issue_reg_write,
   input  logic       wb_valid,
   input  logic [4:0] wb_rd,
   input  logic       flush,
   output logic       stall,
   output logic       issue_fire,
   output logic [2:0] inflight,
   output logic       err
);

   localparam logic [2:0]       MAX_CNT = 3'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] SAT_CNT = '1;

   logic [CNT_W-1:0] r_pend [0:31];
   logic [2:0]       r_inflight;
   logic             r_err;

   logic [CNT_W-1:0] w_pendRs1;
   logic [CNT_W-1:0] w_pendRs2;
   logic [CNT_W-1:0] w_pendRd;
   logic [CNT_W-1:0] w_pendWb;
   logic             w_rdTracked;
   logic             w_raw;
   logic             w_full;
   logic             w_sat;
   logic             w_stall;
   logic             w_fire;
   logic             w_issInc;
   logic             w_wbDec;
   logic             w_wbOrphan;

   // Register 0 is forced to read as not pending regardless of array contents.
   always_comb begin
      w_pendRs1   = (issue_rs1 != 5'd0) ? r_pend[issue_rs1] : '0;
      w_pendRs2   = (issue_rs2 != 5'd0) ? r_pend[issue_rs2] : '0;
      w_pendRd    = (issue_rd  != 5'd0) ? r_pend[issue_rd]  : '0;
      w_pendWb    = (wb_rd     != 5'd0) ? r_pend[wb_rd]     : '0;
      w_rdTracked = issue_reg_write && (issue_rd != 5'd0);
      w_raw       = (issue_use_rs1 && (w_pendRs1 != '0)) ||
                    (issue_use_rs2 && (w_pendRs2 != '0));
      w_full      = w_rdTracked && (r_inflight == MAX_CNT);
      w_sat       = w_rdTracked && (w_pendRd == SAT_CNT);
      w_stall     = issue_valid && (w_raw || w_full || w_sat);
      w_fire      = issue_valid && !w_stall;
      w_issInc    = w_fire && w_rdTracked && !flush;
      w_wbDec     = wb_valid && (wb_rd != 5'd0) && (w_pendWb != '0);
      w_wbOrphan  = wb_valid && (wb_rd != 5'd0) && (w_pendWb == '0);
   end

   // Matching issue and write-back on the same register cancel each other out.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int r = 0; r < 32; r++) begin
            r_pend[r] <= '0;
         end
         r_inflight <= 3'd0;
      end else begin
         r_pend[0] <= '0;
         for (int r = 1; r < 32; r++) begin
            if (w_issInc && (issue_rd == 5'(r)) && !(w_wbDec && (wb_rd == 5'(r)))) begin
               r_pend[r] <= r_pend[r] + 1'b1;
            end else if (w_wbDec && (wb_rd == 5'(r)) && !(w_issInc && (issue_rd == 5'(r)))) begin
               r_pend[r] <= r_pend[r] - 1'b1;
            end
         end
         if (w_issInc && !w_wbDec) begin
            r_inflight <= r_inflight + 3'd1;
         end else if (w_wbDec && !w_issInc) begin
            r_inflight <= r_inflight - 3'd1;
         end
      end
   end

   // Error flag survives flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_wbOrphan) begin
         r_err <= 1'b1;
      end
   end

   assign stall      = w_stall;
   assign issue_fire = w_fire;
   assign inflight   = r_inflight;
   assign err        = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with hand-computed
// expectations covering load-use, WAW saturation, capacity, flush and x0.
module tb_hazard_scoreboard;

   logic       clk;
   logic       rst;
   logic       issueValid;
   logic [4:0] issueRs1;
   logic [4:0] issueRs2;
   logic       issueUseRs1;
   logic       issueUseRs2;
   logic [4:0] issueRd;
   logic       issueRegWrite;
   logic       wbValid;
   logic [4:0] wbRd;
   logic       flush;
   logic       stall;
   logic       issueFire;
   logic [2:0] inflight;
   logic       err;

   int errCount   = 0;
   int checkCount = 0;

   hazard_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issueValid),
      .issue_rs1      (issueRs1),
      .issue_rs2      (issueRs2),
      .issue_use_rs1  (issueUseRs1),
      .issue_use_rs2  (issueUseRs2),
      .issue_rd       (issueRd),
      .issue_reg_write(issueRegWrite),
      .wb_valid       (wbValid),
      .wb_rd          (wbRd),
      .flush          (flush),
      .stall          (stall),
      .issue_fire     (issueFire),
      .inflight       (inflight),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs settle before the check.
   task automatic applyStimulus(input logic iv, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic rw,
                                input logic wv, input logic [4:0] wrd, input logic fl);
      issueValid    = iv;
      issueRs1      = rs1;
      issueUseRs1   = u1;
      issueRs2      = rs2;
      issueUseRs2   = u2;
      issueRd       = rd;
      issueRegWrite = rw;
      wbValid       = wv;
      wbRd          = wrd;
      flush         = fl;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic issueWrite(input logic [4:0] rd);
      applyStimulus(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
   endtask

   task automatic writeBack(input logic [4:0] rd);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, rd, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      issueValid = 1'b1;
      #1;
      checkOutput("resetStall", stall, 0);
      checkOutput("resetFire", issueFire, 1);
      step();
      step();
      rst = 1'b0;
      idle();
      checkOutput("resetInflight", inflight, 0);
      checkOutput("resetErr", err, 0);

      // Load-use
      issueWrite(5);
      checkOutput("luIssueFire", issueFire, 1);
      step();
      checkOutput("luInflight1", inflight, 1);
      applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("luRawStall", stall, 1);
      checkOutput("luRawNoFire", issueFire, 0);
      applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
      checkOutput("luSameCycleWbStall", stall, 1);
      step();
      applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("luInflight0", inflight, 0);
      checkOutput("luStallCleared", stall, 0);
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      checkOutput("luRs2Clear", stall, 0);
      step();
      idle();

      // WAW saturation
      for (int i = 0; i < 3; i++) begin
         issueWrite(7);
         checkOutput("wawFire", issueFire, 1);
         step();
      end
      checkOutput("wawInflight3", inflight, 3);
      issueWrite(7);
      checkOutput("wawSatStall", stall, 1);
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
      checkOutput("wawSatSameCycleWb", stall, 1);
      step();
      issueWrite(7);
      checkOutput("wawInflightAfterWb", inflight, 2);
      checkOutput("wawFourthIssues", stall, 0);
      step();
      idle();
      checkOutput("wawInflightBack3", inflight, 3);
      for (int i = 0; i < 3; i++) begin
         writeBack(7);
         step();
      end
      idle();
      checkOutput("wawDrained", inflight, 0);
      checkOutput("wawNoErr", err, 0);

      // Capacity
      for (int r = 1; r <= 4; r++) begin
         issueWrite(5'(r));
         step();
      end
      idle();
      checkOutput("capInflight4", inflight, 4);
      issueWrite(6);
      checkOutput("capFullStall", stall, 1);
      applyStimulus(1, 9, 1, 0, 0, 6, 0, 0, 0, 0);
      checkOutput("capNoWriteNotStalled", stall, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("capRdZeroNotFull", stall, 0);
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
      checkOutput("capRawOnRs2", stall, 1);
      for (int r = 1; r <= 4; r++) begin
         writeBack(5'(r));
         step();
      end
      idle();
      checkOutput("capDrained", inflight, 0);

      // Simultaneous issue and write-back on one register
      issueWrite(8);
      step();
      applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 8, 0);
      checkOutput("simFire", issueFire, 1);
      step();
      idle();
      checkOutput("simInflight", inflight, 1);
      checkOutput("simErr", err, 0);
      applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("simPend8Still", stall, 1);
      writeBack(8);
      step();
      applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("simPend8Clear", stall, 0);
      checkOutput("simInflight0", inflight, 0);
      idle();

      // Flush and sticky error
      issueWrite(11);
      step();
      issueWrite(12);
      step();
      issueWrite(13);
      step();
      idle();
      checkOutput("flInflight3", inflight, 3);
      applyStimulus(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
      checkOutput("flFireDuringFlush", issueFire, 1);
      step();
      idle();
      checkOutput("flInflight0", inflight, 0);
      applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("flPend10Zero", stall, 0);
      applyStimulus(1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("flPend12Zero", stall, 0);
      writeBack(10);
      checkOutput("flErrBeforeEdge", err, 0);
      step();
      idle();
      checkOutput("flErrSet", err, 1);
      checkOutput("flOrphanNoWrap", inflight, 0);
      step();
      step();
      checkOutput("flErrSticky", err, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      idle();
      checkOutput("flErrSurvivesFlush", err, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("flErrClearedByRst", err, 0);

      // x0 handling
      applyStimulus(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
      checkOutput("x0NoStall", stall, 0);
      step();
      idle();
      checkOutput("x0Inflight0", inflight, 0);
      writeBack(0);
      step();
      idle();
      checkOutput("x0WbNoErr", err, 0);

      // Mid-operation reset discards pending writes silently
      issueWrite(3);
      step();
      idle();
      checkOutput("mrInflight1", inflight, 1);
      rst = 1'b1;
      issueWrite(4);
      checkOutput("mrFireInReset", issueFire, 1);
      step();
      rst = 1'b0;
      idle();
      checkOutput("mrInflight0", inflight, 0);
      checkOutput("mrErr0", err, 0);
      applyStimulus(1, 3, 1, 4, 1, 0, 0, 0, 0, 0);
      checkOutput("mrPendCleared", stall, 0);
      idle();

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
